// File: rtl/dmem_multiport.sv
// Multi-port data-memory controller: round-robin arbitration of N_PORT requesters onto one
// single-port word RAM with tagged, fixed-latency responses. Optional macro: DMEM_BYTE_WE_EN.
module dmem_multiport #(
  parameter int N_PORT     = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int RD_LAT     = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_PORT-1:0]          req_valid,
  input  logic [N_PORT-1:0]          req_we,
  input  logic [N_PORT*ADDR_W-1:0]   req_addr,
  input  logic [N_PORT*DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_WE_EN
  input  logic [N_PORT*DATA_W/8-1:0] req_be,
`endif
  output logic [N_PORT-1:0]          req_ready,
  output logic [N_PORT-1:0]          rsp_valid,
  output logic [N_PORT*DATA_W-1:0]   rsp_rdata
);

  localparam int PTR_W  = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  logic [PTR_W-1:0]      rr_ptr_reg;
  logic [PTR_W-1:0]      rr_ptr_next;
  logic [2*N_PORT-1:0]   valid_dbl;
  logic [N_PORT-1:0]     valid_rot;
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W:0]        grant_sum;
  logic [PTR_W:0]        ptr_sum;
  logic                  fire;

  logic [ADDR_W-1:0]     sel_addr;
  logic                  sel_we;
  logic [DATA_W-1:0]     sel_wdata;
  logic [NB-1:0]         sel_be;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  unused_addr_bits;

  logic [DATA_W-1:0]     mem [0:DEPTH-1];
  logic [DATA_W-1:0]     rd_q_reg;
  logic [DATA_W-1:0]     rsp_word;

  logic [RD_LAT-1:0]     tag_valid_reg;
  logic [RD_LAT-1:0]     tag_we_reg;
  logic [PTR_W-1:0]      tag_port_reg [0:RD_LAT-1];

  // Rotate the valid vector so the search always starts at bit 0 == rr_ptr.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = N_PORT'(valid_dbl >> rr_ptr_reg);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_sum = '0;
    for (int k = 0; k < N_PORT; k++) begin
      if (!grant_any && valid_rot[k]) begin
        grant_any = 1'b1;
        grant_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
        if (grant_sum >= (PTR_W+1)'(N_PORT)) begin
          grant_sum = grant_sum - (PTR_W+1)'(N_PORT);
        end
        grant_idx = grant_sum[PTR_W-1:0];
      end
    end
  end

  assign fire      = grant_any && rstn;
  assign req_ready = fire ? (N_PORT'(1) << grant_idx) : '0;

  always_comb begin
    ptr_sum = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (ptr_sum >= (PTR_W+1)'(N_PORT)) begin
      ptr_sum = '0;
    end
    rr_ptr_next = ptr_sum[PTR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_reg <= '0;
    end else if (grant_any) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_be    = '1;
    for (int k = 0; k < N_PORT; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        sel_we    = req_we[k];
        sel_wdata = req_wdata[k*DATA_W +: DATA_W];
`ifdef DMEM_BYTE_WE_EN
        sel_be    = req_be[k*NB +: NB];
`endif
      end
    end
  end

  // Byte offset and bits above the RAM depth are dropped, so addresses wrap.
  assign widx             = sel_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{sel_addr[ADDR_W-1:DEPTH_LOG2+2], sel_addr[1:0]};

  always_ff @(posedge clk) begin
    if (fire && sel_we) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_be[b]) begin
          mem[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
    if (fire && !sel_we) begin
      rd_q_reg <= mem[widx];
    end
  end

  generate
    if (RD_LAT == 1) begin : g_no_pipe
      assign rsp_word = rd_q_reg;
    end else begin : g_pipe
      logic [DATA_W-1:0] rdata_pipe_reg [0:RD_LAT-2];
      always_ff @(posedge clk) begin
        rdata_pipe_reg[0] <= rd_q_reg;
        for (int s = 1; s < RD_LAT-1; s++) begin
          rdata_pipe_reg[s] <= rdata_pipe_reg[s-1];
        end
      end
      assign rsp_word = rdata_pipe_reg[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_valid_reg <= '0;
    end else begin
      tag_valid_reg[0] <= fire;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_port_reg[0] <= grant_idx;
    tag_we_reg[0]   <= sel_we;
    for (int s = 1; s < RD_LAT; s++) begin
      tag_port_reg[s] <= tag_port_reg[s-1];
      tag_we_reg[s]   <= tag_we_reg[s-1];
    end
  end

  // Writes return a zero word as their acknowledge.
  for (genvar gi = 0; gi < N_PORT; gi++) begin : g_rsp
    logic hit;
    assign hit           = tag_valid_reg[RD_LAT-1] && (tag_port_reg[RD_LAT-1] == PTR_W'(gi));
    assign rsp_valid[gi] = hit;
    assign rsp_rdata[gi*DATA_W +: DATA_W] = (hit && !tag_we_reg[RD_LAT-1]) ? rsp_word : '0;
  end

endmodule
